// File: rtl/writeback_unit.sv
// Register-file write-back stage: merges single-cycle ALU results and memory
// load returns onto one write port, with a one-entry ALU hold buffer.
module writeback_unit #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_off,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              ld_busy,
  output logic [ADDR_W-1:0] ld_pending_rd,
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [XLEN-1:0]   wd3
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ld_rd_q, ld_rd_d;
  logic [2:0]        ld_f3_q, ld_f3_d;
  logic [1:0]        ld_off_q, ld_off_d;
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_rd_q, buf_rd_d;
  logic [XLEN-1:0]   buf_data_q, buf_data_d;
  logic              alu_ready_q, alu_ready_d;
  logic              we3_q, we3_d;
  logic [ADDR_W-1:0] wa3_q, wa3_d;
  logic [XLEN-1:0]   wd3_q, wd3_d;

  logic              ld_done;
  logic              alu_take;
  logic              buf_drain;
  logic [XLEN-1:0]   ld_shift;
  logic [XLEN-1:0]   ld_data;

  always_comb begin
    ld_shift = mem_rdata >> {ld_off_q, 3'b000};
    case (ld_f3_q)
      3'b000:  ld_data = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ld_rd_d     = ld_rd_q;
    ld_f3_d     = ld_f3_q;
    ld_off_d    = ld_off_q;
    buf_valid_d = buf_valid_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
    we3_d       = 1'b0;
    wa3_d       = wa3_q;
    wd3_d       = wd3_q;
    buf_drain   = 1'b0;

    ld_done  = (state_q == ST_WAIT) && mem_rvalid;
    // x0 ALU results complete the handshake but never compete for the port
    alu_take = alu_valid && alu_ready_q && (alu_rd != '0);

    case (state_q)
      ST_IDLE: begin
        if (ld_valid) begin
          state_d  = ST_WAIT;
          ld_rd_d  = ld_rd;
          ld_f3_d  = ld_funct3;
          ld_off_d = ld_off;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A completing load owns the port even when it targets x0
    if (ld_done) begin
      if (ld_rd_q != '0) begin
        we3_d = 1'b1;
        wa3_d = ld_rd_q;
        wd3_d = ld_data;
      end
      if (alu_take) begin
        buf_valid_d = 1'b1;
        buf_rd_d    = alu_rd;
        buf_data_d  = alu_result;
      end
    end else if (buf_valid_q) begin
      we3_d       = 1'b1;
      wa3_d       = buf_rd_q;
      wd3_d       = buf_data_q;
      buf_valid_d = 1'b0;
      buf_drain   = 1'b1;
    end else if (alu_take) begin
      we3_d = 1'b1;
      wa3_d = alu_rd;
      wd3_d = alu_result;
    end

    // Ready stays low for the cycle the drained entry is on the port
    alu_ready_d = !buf_valid_d && !buf_drain;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ld_rd_q     <= '0;
      ld_f3_q     <= '0;
      ld_off_q    <= '0;
      buf_valid_q <= 1'b0;
      buf_rd_q    <= '0;
      buf_data_q  <= '0;
      alu_ready_q <= 1'b1;
      we3_q       <= 1'b0;
      wa3_q       <= '0;
      wd3_q       <= '0;
    end else begin
      state_q     <= state_d;
      ld_rd_q     <= ld_rd_d;
      ld_f3_q     <= ld_f3_d;
      ld_off_q    <= ld_off_d;
      buf_valid_q <= buf_valid_d;
      buf_rd_q    <= buf_rd_d;
      buf_data_q  <= buf_data_d;
      alu_ready_q <= alu_ready_d;
      we3_q       <= we3_d;
      wa3_q       <= wa3_d;
      wd3_q       <= wd3_d;
    end
  end

  assign alu_ready     = alu_ready_q;
  assign ld_ready      = (state_q == ST_IDLE);
  assign ld_busy       = (state_q == ST_WAIT);
  assign ld_pending_rd = (state_q == ST_WAIT) ? ld_rd_q : '0;
  assign we3           = we3_q;
  assign wa3           = wa3_q;
  assign wd3           = wd3_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed literal checks plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_result = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_rd = '0;
  logic [2:0]  ld_funct3 = '0;
  logic [1:0]  ld_off = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        ld_busy;
  logic [4:0]  ld_pending_rd;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;

  int checks = 0;
  int errors = 0;

  writeback_unit #(.ADDR_W(5), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_result(alu_result),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_off(ld_off),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ld_busy(ld_busy), .ld_pending_rd(ld_pending_rd),
    .we3(we3), .wa3(wa3), .wd3(wd3)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [4:0] rd; logic [31:0] data; } wr_t;
  wr_t         alu_q[$];
  logic        m_busy, m_alu_ready, m_we;
  logic [4:0]  m_ld_rd, m_wa;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  logic [31:0] m_wd;

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
    logic [31:0] w;
    int          v;
    w = rdata >> (8 * int'(off));
    case (f3)
      3'd0: v = int'($signed(w[7:0]));
      3'd1: v = int'($signed(w[15:0]));
      3'd4: v = int'(w[7:0]);
      3'd5: v = int'(w[15:0]);
      default: v = int'(w);
    endcase
    return 32'(v);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q.delete();
      m_busy = 0; m_alu_ready = 1; m_we = 0; m_wa = 0; m_wd = 0;
      m_ld_rd = 0; m_f3 = 0; m_off = 0;
    end else begin
      logic done, accept, start, drained;
      done    = m_busy && mem_rvalid;
      accept  = alu_valid && m_alu_ready && alu_rd != 0;
      start   = !m_busy && ld_valid;
      drained = 0;
      m_we    = 0;
      if (done) begin
        if (m_ld_rd != 0) begin
          m_we = 1; m_wa = m_ld_rd; m_wd = load_value(m_f3, m_off, mem_rdata);
        end
        if (accept) alu_q.push_back('{alu_rd, alu_result});
      end else if (alu_q.size() > 0) begin
        wr_t e;
        e = alu_q.pop_front();
        m_we = 1; m_wa = e.rd; m_wd = e.data; drained = 1;
      end else if (accept) begin
        m_we = 1; m_wa = alu_rd; m_wd = alu_result;
      end
      if (done) m_busy = 0;
      if (start) begin
        m_busy = 1; m_ld_rd = ld_rd; m_f3 = ld_funct3; m_off = ld_off;
      end
      m_alu_ready = (alu_q.size() == 0) && !drained;
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    checks++;
    if (we3 !== m_we || alu_ready !== m_alu_ready || ld_ready !== !m_busy ||
        ld_busy !== m_busy || ld_pending_rd !== (m_busy ? m_ld_rd : 5'd0) ||
        wa3 !== m_wa || wd3 !== m_wd) begin
      errors++;
      $display("FAIL model t=%0t got we3=%b wa3=%0d wd3=%h ar=%b lr=%b busy=%b prd=%0d expected we3=%b wa3=%0d wd3=%h ar=%b lr=%b busy=%b prd=%0d",
               $time, we3, wa3, wd3, alu_ready, ld_ready, ld_busy, ld_pending_rd,
               m_we, m_wa, m_wd, m_alu_ready, !m_busy, m_busy, m_busy ? m_ld_rd : 5'd0);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
    ld_valid = 1; ld_rd = rd; ld_funct3 = f3; ld_off = off;
    tick();
    ld_valid = 0;
  endtask

  task automatic respond(input logic [31:0] data);
    mem_rvalid = 1; mem_rdata = data;
    tick();
    mem_rvalid = 0;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    #1;
    chk("reset_we3", 32'(we3), 32'd0);
    chk("reset_wa3", 32'(wa3), 32'd0);
    chk("reset_wd3", wd3, 32'd0);
    chk("reset_alu_ready", 32'(alu_ready), 32'd1);
    chk("reset_ld_ready", 32'(ld_ready), 32'd1);
    chk("reset_ld_busy", 32'(ld_busy), 32'd0);
    chk("reset_pending_rd", 32'(ld_pending_rd), 32'd0);
    @(posedge clk); #1;

    alu_valid = 1; alu_rd = 5; alu_result = 32'h1234;
    tick();
    alu_valid = 0;
    chk("alu_we3", 32'(we3), 32'd1);
    chk("alu_wa3", 32'(wa3), 32'd5);
    chk("alu_wd3", wd3, 32'h1234);
    chk("alu_ready_high", 32'(alu_ready), 32'd1);

    issue_load(7, 3'b000, 2'd2);
    chk("lb_busy", 32'(ld_busy), 32'd1);
    chk("lb_pending", 32'(ld_pending_rd), 32'd7);
    chk("lb_ld_ready_low", 32'(ld_ready), 32'd0);
    chk("lb_no_write_yet", 32'(we3), 32'd0);
    tick();
    chk("lb_still_busy", 32'(ld_busy), 32'd1);
    respond(32'h0080_0000);
    chk("lb_we3", 32'(we3), 32'd1);
    chk("lb_wa3", 32'(wa3), 32'd7);
    chk("lb_wd3", wd3, 32'hFFFF_FF80);
    chk("lb_ld_ready", 32'(ld_ready), 32'd1);
    chk("lb_busy_clear", 32'(ld_pending_rd), 32'd0);

    issue_load(8, 3'b101, 2'd2);
    respond(32'hBEEF_0000);
    chk("lhu_wd3", wd3, 32'h0000_BEEF);
    issue_load(9, 3'b001, 2'd0);
    respond(32'h0000_8001);
    chk("lh_wd3", wd3, 32'hFFFF_8001);

    issue_load(3, 3'b010, 2'd0);
    mem_rvalid = 1; mem_rdata = 32'hAAAA_0000;
    alu_valid = 1; alu_rd = 4; alu_result = 32'h55;
    tick();
    mem_rvalid = 0; alu_valid = 0;
    chk("col_c1_wa3", 32'(wa3), 32'd3);
    chk("col_c1_wd3", wd3, 32'hAAAA_0000);
    chk("col_c1_alu_ready", 32'(alu_ready), 32'd0);
    tick();
    chk("col_c2_we3", 32'(we3), 32'd1);
    chk("col_c2_wa3", 32'(wa3), 32'd4);
    chk("col_c2_wd3", wd3, 32'h55);
    tick();
    chk("col_c3_alu_ready", 32'(alu_ready), 32'd1);
    chk("col_c3_we3", 32'(we3), 32'd0);

    alu_valid = 1; alu_rd = 0; alu_result = 32'hDEAD;
    chk("x0_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 0;
    chk("x0_alu_no_we", 32'(we3), 32'd0);
    issue_load(0, 3'b010, 2'd0);
    chk("x0_ld_busy", 32'(ld_busy), 32'd1);
    respond(32'hCAFE_F00D);
    chk("x0_ld_no_we", 32'(we3), 32'd0);
    chk("x0_ld_idle", 32'(ld_ready), 32'd1);

    issue_load(9, 3'b010, 2'd0);
    #2 rst_n = 0;
    #2 rst_n = 1;
    @(posedge clk); #1;
    respond(32'h1111_2222);
    chk("rst_no_we", 32'(we3), 32'd0);
    chk("rst_busy", 32'(ld_busy), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);

    for (int i = 0; i < 4000; i++) begin
      alu_valid  = ($urandom % 2) == 0;
      alu_rd     = (($urandom % 5) == 0) ? 5'd0 : 5'($urandom);
      alu_result = $urandom;
      ld_valid   = ($urandom % 3) == 0;
      ld_rd      = (($urandom % 6) == 0) ? 5'd0 : 5'($urandom);
      ld_funct3  = 3'($urandom);
      ld_off     = 2'($urandom);
      mem_rvalid = ($urandom % 5) < 2;
      mem_rdata  = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 0;
        #2 rst_n = 1;
      end
      tick();
    end
    alu_valid = 0; ld_valid = 0; mem_rvalid = 0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage ahead of the register file. Owns its single write port (we3/wa3/wd3).
- Merges two result sources:
  - single-cycle ALU results;
  - load results returned from data memory, which are sign/zero-extended and byte-lane aligned here.
- Arbitrates both sources onto the one write port, with a one-entry ALU hold buffer.
- Exports load-pending status for hazard detection.

Parameters:
- ADDR_W, 5, register index width
- XLEN, 32, data width (byte/half extraction requires XLEN=32)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result presented
- alu_ready  out  1  ALU result accepted when alu_valid&&alu_ready
- alu_rd  in  ADDR_W  ALU destination register
- alu_result  in  XLEN  ALU result value
- ld_valid  in  1  load issued to memory this cycle
- ld_ready  out  1  unit can accept a load
- ld_rd  in  ADDR_W  load destination register
- ld_funct3  in  3  load type (RISC-V funct3)
- ld_off  in  2  byte offset, addr[1:0]
- mem_rvalid  in  1  memory read data valid
- mem_rdata  in  XLEN  memory read word
- ld_busy  out  1  load outstanding
- ld_pending_rd  out  ADDR_W  destination of outstanding load, 0 when idle
- we3  out  1  register file write enable
- wa3  out  ADDR_W  register file write address
- wd3  out  XLEN  register file write data

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - we3=0, wa3=0, wd3=0
  - FSM in IDLE, hold buffer empty
  - alu_ready=1, ld_ready=1, ld_busy=0, ld_pending_rd=0
- Load FSM states: IDLE, WAIT.
  - ld_ready = (state==IDLE).
  - IDLE→WAIT on ld_valid&&ld_ready. On that edge, capture ld_rd, ld_funct3 and ld_off.
  - WAIT→IDLE on mem_rvalid; this produces one load completion.
  - In WAIT, ld_valid is ignored.
  - In IDLE, mem_rvalid is ignored.
  - At most one load is outstanding.
- Busy outputs: ld_busy = (state==WAIT). ld_pending_rd = captured rd in WAIT, else 0.
- Load data formation, with w = mem_rdata >> (8*off):
  - 000 LB: sign-extend w[7:0]
  - 001 LH: sign-extend w[15:0]
  - 010 LW: w
  - 100 LBU: zero-extend w[7:0]
  - 101 LHU: zero-extend w[15:0]
  - Any other funct3 is treated as LW.
  - Misalignment is handled upstream; it is not checked here.
- x0 handling:
  - A load or ALU result with rd==0 never asserts we3.
  - An ALU result with rd==0 is accepted (handshake completes) and discarded. It never enters the buffer.
  - A load with rd==0 still occupies WAIT until mem_rvalid.
- Write-port arbitration, at most one write per cycle. Priority, highest first:
  1. load completion
  2. held ALU entry
  3. incoming accepted ALU result
- ALU hold buffer: one entry.
  - alu_ready = !buf_valid, taken from a register (no combinational path from inputs).
  - An accepted ALU result (rd!=0) that loses arbitration is written into the buffer.
  - The buffer drains in the first cycle with no load completion. alu_ready returns high the following cycle.
- Latency: the winning candidate appears on we3/wa3/wd3 registered, one cycle after the deciding edge.
  - ALU accepted into an empty-buffer, no-load cycle: write on the next edge.
  - Load: we3 asserts the cycle after mem_rvalid.
  - When no candidate wins, we3=0 and wa3/wd3 hold their last values.
- Ordering: source interleaving is the issuer's responsibility. Within the ALU stream, order is always preserved (buffer entry before incoming).
- Reset mid-WAIT: the load is abandoned and the buffer cleared. A later mem_rvalid is ignored (FSM is in IDLE). No write results.

Test Plan:
- Reset, then alu_valid with rd=5, result=0x1234 → next cycle we3=1, wa3=5, wd3=0x1234; alu_ready stays 1.
- LB with off=2, mem_rdata=0x00800000, rd=7 → ld_busy=1 and ld_pending_rd=7 until mem_rvalid; then we3=1, wa3=7, wd3=0xFFFFFF80; ld_ready=1 again.
- LHU with off=2, rdata=0xBEEF0000 → wd3=0x0000BEEF. LH with off=0, rdata=0x00008001 → wd3=0xFFFF8001.
- Collision: mem_rvalid (load rd=3, LW 0xAAAA0000) in the same cycle as ALU rd=4, 0x55 → cycle+1 writes x3; alu_ready=0; cycle+2 writes x4=0x55; alu_ready=1 at cycle+3.
- ALU rd=0, and LW rd=0 with response → we3 never asserts; both handshakes complete.
- ld accepted, rst_n pulsed low during WAIT, then mem_rvalid=1 → no write; ld_busy=0; ld_ready=1.
